// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
// btn_debounce: synchronise and debounce one raw push-button pin.
//   Produces a clean pressed level plus one-cycle press/release strobes,
//   and optionally a one-cycle long-press strobe.
// Optional feature macro: BTN_LONGPRESS_EN (enables long_p; otherwise long_p = 0).
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_raw    raw, bouncy, asynchronous button pin
//   btn_db     debounced level, 1 = pressed
//   press_p    one-cycle strobe on btn_db 0->1
//   release_p  one-cycle strobe on btn_db 1->0
//   long_p     one-cycle strobe LONG_CYC cycles after press_p while still held
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned LONG_CYC     = 50000000,
  parameter bit          BTN_ACTIVE   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db,
  output logic press_p,
  output logic release_p,
  output logic long_p
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYC);

  // Elaboration-time parameter sanity checks
  if (DEBOUNCE_CYC < 1) begin : g_chk_deb
    $error("btn_debounce: DEBOUNCE_CYC must be >= 1");
  end
  if (LONG_CYC < 1) begin : g_chk_long
    $error("btn_debounce: LONG_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             pin_n;
  logic             s;
  logic             btn_db_d;
  logic             press_d;
  logic             release_d;

  // Normalise polarity so 1 always means pressed
  assign pin_n = btn_raw ^ ~BTN_ACTIVE;
  assign s     = sync_q[1];

  // Two-flop synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pin_n};
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      btn_db    <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_db    <= btn_db_d;
      press_p   <= press_d;
      release_p <= release_d;
    end
  end

  // Next-state and stability counter; cnt stops at DEB_MAX so it never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_PEND;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_PEND: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_PEND;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_PEND: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: strobes fire on the same edge that commits the level change
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    btn_db_d  = btn_db;
    if ((state_q == PRESS_PEND) && s && (cnt_q == DEB_MAX)) begin
      press_d  = 1'b1;
      btn_db_d = 1'b1;
    end
    if ((state_q == RELEASE_PEND) && !s && (cnt_q == DEB_MAX)) begin
      release_d = 1'b1;
      btn_db_d  = 1'b0;
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int unsigned LCNT_W = $clog2(LONG_CYC + 1);
  localparam logic [LCNT_W-1:0] LONG_MAX  = LCNT_W'(LONG_CYC);
  localparam logic [LCNT_W-1:0] LONG_LAST = LCNT_W'(LONG_CYC - 1);

  logic [LCNT_W-1:0] lcnt_q;

  // Hold-time counter; saturates at LONG_MAX so long_p fires once per press.
  // Bounces that stay inside RELEASE_PEND keep btn_db high and do not restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      long_p <= 1'b0;
    end else begin
      long_p <= 1'b0;
      if (press_d || release_d) begin
        lcnt_q <= '0;
      end else if (btn_db && (lcnt_q < LONG_MAX)) begin
        lcnt_q <= lcnt_q + LCNT_W'(1);
        if (lcnt_q == LONG_LAST) begin
          long_p <= 1'b1;
        end
      end
    end
  end
`else
  assign long_p = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
`timescale 1ns/1ps
// tb_btn_debounce: directed stimulus with a strobe scoreboard.
// Expected strobes (kind + posedge index) are queued when the pin is driven;
// a monitor pops and compares them as strobes appear.
// Timing convention: pin driven at a negedge is first sampled by the next
// posedge P; btn_db and its strobe are visible just after posedge P+10.
module tb_btn_debounce;

  localparam int unsigned DEB  = 8;
  localparam int unsigned LONG = 32;
  localparam int          LAT  = 2 + DEB;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  logic btn_raw;
  logic btn_db;
  logic press_p;
  logic release_p;
  logic long_p;

  int  cyc;
  int  n_checks;
  int  n_fail;
  ev_t sb[$];

  btn_debounce #(
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LONG),
    .BTN_ACTIVE  (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_db   (btn_db),
    .press_p  (press_p),
    .release_p(release_p),
    .long_p   (long_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge index
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Wait until just after posedge c (sampled at the following negedge)
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive the pin at a negedge and queue the strobe it should cause
  task automatic drive_edge(input logic v, input int kind, output int t);
    @(negedge clk);
    btn_raw = v;
    t = cyc + 1 + LAT;
    sb.push_back('{kind: kind, cyc: t});
  endtask

  // Strobe monitor / scoreboard consumer
  always @(posedge clk) begin
    ev_t        e;
    logic [2:0] st;
    #1;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk($sformatf("missed_strobe_k%0d", e.kind), 32'(cyc), 32'(e.cyc));
    end
    if (rst_n) begin
      st = {long_p, release_p, press_p};
      if (press_p || release_p)
        chk("strobe_exclusive", 32'(press_p & release_p), 32'd0);
      for (int k = 0; k < 3; k++) begin
        if (st[k]) begin
          if (sb.size() > 0) e = sb.pop_front();
          else e = '{kind: -1, cyc: -1};
          chk($sformatf("strobe_kind_k%0d", k), 32'(k), 32'(e.kind));
          chk($sformatf("strobe_cycle_k%0d", k), 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int t2;
    int c0;
    n_checks = 0;
    n_fail   = 0;

    // 1. Reset with button held, then release
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_btn_db", 32'(btn_db), 32'd0);
    chk("rst_press_p", 32'(press_p), 32'd0);
    chk("rst_release_p", 32'(release_p), 32'd0);
    chk("rst_long_p", 32'(long_p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc + 1 + LAT;
    sb.push_back('{kind: K_PRESS, cyc: t});
    wait_to(t - 1);
    chk("t1_btn_db_before", 32'(btn_db), 32'd0);
    wait_to(t);
    chk("t1_btn_db_after", 32'(btn_db), 32'd1);
    chk("t1_press_p", 32'(press_p), 32'd1);
    wait_to(t + 1);
    chk("t1_press_single", 32'(press_p), 32'd0);
    drive_edge(1'b0, K_RELEASE, t2);
    wait_to(t2);
    chk("t1_btn_db_rel", 32'(btn_db), 32'd0);
    wait_to(t2 + 3);

    // 2. Clean 0->1 step
    drive_edge(1'b1, K_PRESS, t);
    wait_to(t - 1);
    chk("t2_btn_db_before", 32'(btn_db), 32'd0);
    wait_to(t);
    chk("t2_btn_db_after", 32'(btn_db), 32'd1);
    wait_to(t + 1);
    chk("t2_press_single", 32'(press_p), 32'd0);
    drive_edge(1'b0, K_RELEASE, t2);
    wait_to(t2 - 1);
    chk("t2_btn_db_hold", 32'(btn_db), 32'd1);
    wait_to(t2);
    chk("t2_release_p", 32'(release_p), 32'd1);
    wait_to(t2 + 3);

    // 3. Bounce 1,0,1,0 every 3 cycles, then steady 1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) @(negedge clk);
    end
    drive_edge(1'b1, K_PRESS, t);
    wait_to(t - 1);
    chk("t3_btn_db_before", 32'(btn_db), 32'd0);
    wait_to(t);
    chk("t3_btn_db_after", 32'(btn_db), 32'd1);
    drive_edge(1'b0, K_RELEASE, t2);
    wait_to(t2 + 3);
    chk("t3_btn_db_rel", 32'(btn_db), 32'd0);

    // 4. 5-cycle high glitch from idle
    @(negedge clk);
    btn_raw = 1'b1;
    repeat (5) @(negedge clk);
    btn_raw = 1'b0;
    c0 = cyc;
    wait_to(c0 + 20);
    chk("t4_btn_db_glitch", 32'(btn_db), 32'd0);

    // 5. Hold 60 cycles, then release
    drive_edge(1'b1, K_PRESS, t);
`ifdef BTN_LONGPRESS_EN
    sb.push_back('{kind: K_LONG, cyc: t + int'(LONG)});
`endif
    repeat (59) @(negedge clk);
    drive_edge(1'b0, K_RELEASE, t2);
    wait_to(t + int'(LONG));
`ifdef BTN_LONGPRESS_EN
    chk("t5_long_p", 32'(long_p), 32'd1);
`else
    chk("t5_long_p", 32'(long_p), 32'd0);
`endif
    wait_to(t2 - 1);
    chk("t5_btn_db_hold", 32'(btn_db), 32'd1);
    wait_to(t2);
    chk("t5_btn_db_rel", 32'(btn_db), 32'd0);
    wait_to(t2 + 40);

    // 6. Reset in PRESS_PEND at cnt=5 drops the pending press
    @(negedge clk);
    btn_raw = 1'b1;
    c0 = cyc + 1;
    wait_to(c0 + 6);
    rst_n = 1'b0;
    #1;
    chk("t6_btn_db", 32'(btn_db), 32'd0);
    chk("t6_press_p", 32'(press_p), 32'd0);
    chk("t6_release_p", 32'(release_p), 32'd0);
    chk("t6_long_p", 32'(long_p), 32'd0);
    btn_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    wait_to(c0 + 20);
    chk("t6_btn_db_dropped", 32'(btn_db), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
